instr_sequencer: RTL and testbench

Parametrised instruction sequencer between a synchronous program ROM and the board processor, replacing the free-running address counter and separate memory/processor clocks with a single-clock handshake. It fetches words from ROM, issues each instruction to the processor with a one-cycle `run` pulse, supplies immediate words on request, and advances only on the processor's `done`. It supports free-run and single-step modes, instruction counting, a stall watchdog and an optional address breakpoint; `pc`, `din` and `instr_cnt` feed the hex displays.

---
 rtl/instr_sequencer.sv | 165 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Single-clock sequencer between a synchronous program ROM and the processor: fetch, issue,
// immediate supply and retire handshake. Optional address breakpoint via SEQ_BREAKPOINT_EN.
module instr_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              mode,
    input  logic              go,
    input  logic              step,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] brk_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic              din_valid,
    input  logic              next,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic              halted,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StExec,
        StFetchD,
        StHalted
    } state_e;

    // The watchdog counter only needs to reach TIMEOUT-1 before it fires.
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam bit WD_EN = (TIMEOUT != 0);

    state_e              state_q, state_d, bnd_state;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;
    logic                dv_q, dv_d;
    logic                step_q;
    logic                step_rise;
    logic                bp_hit;

    assign step_rise = step & ~step_q;

`ifdef SEQ_BREAKPOINT_EN
    assign bp_hit = (pc_q == brk_addr);
`else
    logic unused_brk;
    assign unused_brk = ^brk_addr;
    assign bp_hit     = 1'b0;
`endif

    // Where to go once an instruction retires.
    always_comb begin
        bnd_state = StIdle;
        if (halt_req) begin
            bnd_state = StHalted;
        end else if (bp_hit) begin
            bnd_state = StHalted;
        end else if (mode) begin
            bnd_state = StIdle;
        end else if (go) begin
            bnd_state = StFetch;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        din_d      = din_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        dv_d       = (state_q == StFetchD);
        wd_d       = (state_q == StExec) ? wd_q + WD_W'(1) : '0;

        unique case (state_q)
            StIdle: begin
                if (mode ? step_rise : go) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                din_d   = rom_data;
                pc_d    = rom_addr_q;
                state_d = StIssue;
            end
            StIssue: begin
                state_d = StExec;
            end
            StExec: begin
                if (done) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q + CNT_W'(1);
                    state_d    = bnd_state;
                end else if (next) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = StFetchD;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    state_d = StHalted;
                    err_d   = 1'b1;
                end
            end
            StFetchD: begin
                din_d   = rom_data;
                state_d = StExec;
            end
            StHalted: begin
                if (step_rise) begin
                    state_d = StFetch;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            din_q      <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            dv_q       <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            din_q      <= din_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
            dv_q       <= dv_d;
            step_q     <= step;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign din       = din_q;
    assign pc        = pc_q;
    assign instr_cnt = cnt_q;
    assign run       = (state_q == StIssue);
    assign din_valid = dv_q;
    assign halted    = (state_q == StHalted);
    assign err       = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: free-run, single-step table, watchdog, halt request,
// async reset and address wrap / breakpoint.
module tb_instr_sequencer;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int TO = 10;
`ifdef SEQ_BREAKPOINT_EN
    localparam int N_FREE = 4;
`else
    localparam int N_FREE = 33;
`endif

    logic          CLK = 1'b0;
    logic          RSTn = 1'b1;
    logic          mode = 1'b0, go = 1'b0, step = 1'b0, halt_req = 1'b0;
    logic          next = 1'b0, done = 1'b0;
    logic [AW-1:0] brk_addr = 5'd31;
    logic [AW-1:0] rom_addr, pc;
    logic [DW-1:0] rom_data, din;
    logic          run, din_valid, halted, err;
    logic [CW-1:0] instr_cnt;

    logic [DW-1:0] rom [32];
    assign rom_data = rom[rom_addr];

    int n_pass = 0;
    int n_total = 0;
    int run_total = 0;

    instr_sequencer #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .CNT_W  (CW),
        .TIMEOUT(TO)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .mode     (mode),
        .go       (go),
        .step     (step),
        .halt_req (halt_req),
        .brk_addr (brk_addr),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .din      (din),
        .run      (run),
        .din_valid(din_valid),
        .next     (next),
        .done     (done),
        .pc       (pc),
        .instr_cnt(instr_cnt),
        .halted   (halted),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (run) run_total++;

    typedef struct {
        int            n_next;
        bit            hold;
        logic [AW-1:0] exp_pc;
        logic [CW-1:0] exp_cnt;
    } step_vec_t;

    step_vec_t vecs [4];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance until run is seen; reports the number of clock edges taken.
    task automatic wait_run(output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            if (run) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
        check("run_seen", 32'(ok), 32'd1);
    endtask

    task automatic do_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic do_next();
        next = 1'b1;
        tick();
        next = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int            n;
        int            r0;
        logic [AW-1:0] a;

        for (int i = 0; i < 32; i++) rom[i] = 8'hA0 + 8'(i);
        rom[0] = 8'h40;
        rom[1] = 8'h05;
        rom[2] = 8'h81;

        vecs[0] = '{0, 1'b0, 5'd3, 16'd3};
        vecs[1] = '{1, 1'b0, 5'd4, 16'd4};
        vecs[2] = '{2, 1'b0, 5'd6, 16'd5};
        vecs[3] = '{0, 1'b1, 5'd9, 16'd6};

        // Reset values
        #2 RSTn = 1'b0;
        tick();
        tick();
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_din", 32'(din), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_cnt", 32'(instr_cnt), 0);
        check("rst_flags", {run, din_valid, halted, err}, 0);
        RSTn = 1'b1;

        // Free-run: instruction, one immediate, then done
        mode = 1'b0;
        go   = 1'b1;
        wait_run(n);
        check("start_latency", n, 2);
        check("a_din0", 32'(din), 32'h40);
        check("a_pc0", 32'(pc), 0);
        tick();
        do_next();
        check("a_dv_early", 32'(din_valid), 0);
        tick();
        check("a_dv", 32'(din_valid), 1);
        check("a_imm", 32'(din), 32'h05);
        tick();
        check("a_dv_pulse", 32'(din_valid), 0);
        do_done();
        wait_run(n);
        check("done_to_run", n, 1);
        check("a_din2", 32'(din), 32'h81);
        check("a_pc2", 32'(pc), 2);
        check("a_cnt1", 32'(instr_cnt), 1);
        go = 1'b0;
        tick();
        // done and next together: done wins
        next = 1'b1;
        do_done();
        next = 1'b0;
        check("a_cnt2", 32'(instr_cnt), 2);
        check("a_addr3", 32'(rom_addr), 3);
        tick();
        check("a_idle", {run, din_valid, halted}, 0);

        // Single-step table
        mode = 1'b1;
        r0 = run_total;
        foreach (vecs[v]) begin
            step = 1'b1;
            tick();
            if (!vecs[v].hold) step = 1'b0;
            wait_run(n);
            check("s_latency", n, 1);
            check("s_pc", 32'(pc), 32'(vecs[v].exp_pc));
            check("s_din", 32'(din), 32'(rom[vecs[v].exp_pc]));
            tick();
            for (int k = 1; k <= vecs[v].n_next; k++) begin
                do_next();
                tick();
                a = vecs[v].exp_pc + AW'(k);
                check("s_dv", 32'(din_valid), 1);
                check("s_imm", 32'(din), 32'(rom[a]));
            end
            tick();
            do_done();
            a = vecs[v].exp_pc + AW'(vecs[v].n_next + 1);
            check("s_cnt", 32'(instr_cnt), 32'(vecs[v].exp_cnt));
            check("s_addr", 32'(rom_addr), 32'(a));
            n = run_total;
            repeat (3) tick();
            check("s_no_extra_run", run_total, n);
            check("s_not_halted", 32'(halted), 0);
            step = 1'b0;
            tick();
        end
        check("s_run_count", run_total - r0, 4);

        // Watchdog: no done after run
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_run(n);
        check("w_pc", 32'(pc), 10);
        repeat (TO) tick();
        check("w_not_yet", 32'(halted), 0);
        tick();
        check("w_halted", 32'(halted), 1);
        check("w_err", 32'(err), 1);
        check("w_cnt", 32'(instr_cnt), 6);
        check("w_addr", 32'(rom_addr), 10);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("w_err_clr", {halted, err}, 0);
        wait_run(n);
        check("w_refetch_pc", 32'(pc), 10);
        check("w_refetch_din", 32'(din), 32'(rom[10]));
        tick();
        do_done();
        check("w_cnt_after", 32'(instr_cnt), 7);

        // Halt request at the boundary
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_run(n);
        halt_req = 1'b1;
        tick();
        do_done();
        halt_req = 1'b0;
        tick();
        check("h_halted", {halted, err}, 2'b10);
        check("h_cnt", 32'(instr_cnt), 8);
        check("h_addr", 32'(rom_addr), 12);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_run(n);
        check("h_resume_pc", 32'(pc), 12);
        tick();
        do_done();
        check("h_idle", 32'(halted), 0);

        // Async reset while in EXEC
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_run(n);
        tick();
        check("r_pre_addr", 32'(rom_addr), 13);
        #2 RSTn = 1'b0;
        #1;
        check("r_addr", 32'(rom_addr), 0);
        check("r_pc", 32'(pc), 0);
        check("r_din", 32'(din), 0);
        check("r_cnt", 32'(instr_cnt), 0);
        check("r_flags", {run, din_valid, halted, err}, 0);
        tick();
        RSTn = 1'b1;
        tick();
        tick();
        check("r_idle", {run, halted}, 0);

        // Free-run across the address wrap, or into the breakpoint
        brk_addr = 5'd3;
        mode     = 1'b0;
        go       = 1'b1;
        for (int i = 0; i < N_FREE; i++) begin
            wait_run(n);
            a = AW'(i);
            check("f_pc", 32'(pc), 32'(a));
            check("f_din", 32'(din), 32'(rom[a]));
            if (i == N_FREE - 1) go = 1'b0;
            tick();
            do_done();
        end
        tick();
`ifdef SEQ_BREAKPOINT_EN
        check("b_halted", {halted, err}, 2'b10);
        check("b_addr", 32'(rom_addr), 4);
        check("b_cnt", 32'(instr_cnt), 4);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_run(n);
        check("b_resume_pc", 32'(pc), 4);
        tick();
        do_done();
        check("b_cnt_after", 32'(instr_cnt), 5);
        check("b_idle", 32'(halted), 0);
`else
        check("f_cnt", 32'(instr_cnt), 33);
        check("f_addr_wrap", 32'(rom_addr), 1);
        check("f_not_halted", 32'(halted), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
